// File: rtl/mult_pkg.sv
// mult_pkg: shared controller state type and default operand width for the sequential multiplier
package mult_pkg;
   localparam int DEF_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mult_add.sv
// mult_add: WIDTH+1-bit adder for the partial-product accumulate step
//   a, b : WIDTH-bit unsigned addends
//   sum  : low WIDTH bits of a+b
//   cout : carry out of a+b
module mult_add
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/mult32_seq.sv
// mult32_seq: sequential shift-and-add unsigned multiplier, WIDTH RUN cycles per product
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset
//   start   : request a multiply, accepted in IDLE or DONE
//   a, b    : multiplicand / multiplier, sampled on an accepted start
//   busy    : high while the multiply runs
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH-bit result register
//   ovf     : with MULT32_SEQ_OVERFLOW_EN only, upper half of product nonzero
module mult32_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
`ifdef MULT32_SEQ_OVERFLOW_EN
   ,
   output logic                 ovf
`endif
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   state_t            state, state_nx;
   logic [WIDTH-1:0]  mcand, sum;
   logic [CW-1:0]     cnt;
   logic              carry, cout, accept, last;
   logic [WIDTH:0]    upper;
   mult_add #(.WIDTH(WIDTH)) u_add (
      .a    (product[2*WIDTH-1:WIDTH]),
      .b    (mcand),
      .sum  (sum),
      .cout (cout)
   );
   assign last  = cnt == CW'(WIDTH - 1);
   // {carry,high} after the conditional add, before the right shift
   assign upper = product[0] ? {cout, sum} : {carry, product[2*WIDTH-1:WIDTH]};
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      accept   = start && state != RUN;
      state_nx = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
      busy     = state == RUN;
      done     = state == DONE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         mcand   <= '0;
         product <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
      end else if (accept) begin
         mcand   <= a;
         product <= {{WIDTH{1'b0}}, b};
         carry   <= 1'b0;
         cnt     <= '0;
      end else if (busy) begin
         product <= {upper, product[WIDTH-1:1]};
         carry   <= 1'b0;
         cnt     <= cnt + 1'b1;
      end
`ifdef MULT32_SEQ_OVERFLOW_EN
   // upper[WIDTH:1] becomes the high half of product on the final RUN edge
   always_ff @(posedge clk or posedge reset)
      if (reset)             ovf <= 1'b0;
      else if (accept)       ovf <= 1'b0;
      else if (busy && last) ovf <= |upper[WIDTH:1];
`endif
endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq: randomized scoreboard bench for mult32_seq against an arithmetic reference
module tb_mult32_seq;
   localparam int W = 32;
   logic           clk, reset, start;
   logic [W-1:0]   a, b;
   logic           busy, done;
   logic [2*W-1:0] product;
   int             checks = 0, errors = 0;
   logic [2*W-1:0] q[$];
   int             run_len = 0;
   logic           prev_done = 1'b0;
`ifdef MULT32_SEQ_OVERFLOW_EN
   logic           ovf;
`endif

   mult32_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
`ifdef MULT32_SEQ_OVERFLOW_EN
      ,
      .ovf     (ovf)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard whenever done is presented
   always @(negedge clk) begin
      if (reset) begin
         run_len   = 0;
         prev_done = 1'b0;
      end else begin
         if (busy) run_len++;
         if (busy && done) chk("busy_done_exclusive", 1, 0);
         if (done && prev_done) chk("done_single_cycle", 1, 0);
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               automatic logic [2*W-1:0] e = q.pop_front();
               chk("product", product, e);
               chk("busy_cycles", run_len, W);
`ifdef MULT32_SEQ_OVERFLOW_EN
               chk("ovf", ovf, e[2*W-1:W] != 0);
`endif
            end
            run_len = 0;
         end
         prev_done = done;
      end
   end

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      q.push_back({{W{1'b0}}, x} * {{W{1'b0}}, y});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_product", product, 0);
      // start during reset must be ignored
      start = 1'b1;
      a = 32'd5;
      b = 32'd5;
      @(negedge clk);
      chk("start_in_reset_busy", busy, 0);
      chk("start_in_reset_product", product, 0);
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      issue(32'd3, 32'd5);
      chk("first_cycle_busy", busy, 1);
      wait_done();
      repeat (3) @(negedge clk);
      chk("idle_hold_product", product, 64'hF);
      chk("idle_busy", busy, 0);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done();
      // start inside RUN is ignored
      issue(32'd7, 32'd9);
      repeat (8) @(negedge clk);
      a = 32'd1;
      b = 32'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      // reset aborts a running operation
      issue(32'h1234, 32'h10);
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_product", product, 0);
      repeat (2) @(negedge clk);
      q.delete();
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_no_restart", product, 0);
      issue(32'h1234, 32'h10);
      wait_done();
      // back-to-back: start held through DONE
      @(negedge clk);
      a = 32'd2;
      b = 32'd2;
      start = 1'b1;
      q.push_back(64'd4);
      @(negedge clk);
      a = 32'h10000;
      b = 32'h10000;
      wait_done();
      q.push_back(64'h1_0000_0000);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accept_busy", busy, 1);
      wait_done();
      issue(32'd0, 32'hFFFFFFFF);
      wait_done();
      issue(32'hFFFFFFFF, 32'd1);
      wait_done();
      for (int i = 0; i < 16; i++) begin
         issue($urandom, $urandom);
         repeat ($urandom_range(0, 25)) @(negedge clk);
         a = $urandom;
         b = $urandom;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         wait_done();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
